// File: rtl/monolith_hash_arbiter.sv
// Round-robin front end for one fixed-latency, non-stallable Monolith permutation
// engine: issues one state per cycle, tracks requester tags in order, buffers results.
module monolith_hash_arbiter #(
   parameter int WORD_WIDTH = 31,
   parameter int STATE_SIZE = 16,
   parameter int N_REQ      = 4,
   parameter int RSP_DEPTH  = 8,
   parameter int ID_W       = $clog2(N_REQ)
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic [N_REQ-1:0]                                req_valid,
   output logic [N_REQ-1:0]                                req_ready,
   input  logic [N_REQ-1:0][STATE_SIZE-1:0][WORD_WIDTH-1:0] req_state,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]           hash_state_in,
   output logic                                            hash_in_valid,
   input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]           hash_state_out,
   input  logic                                            hash_out_valid,
   output logic                                            rsp_valid,
   input  logic                                            rsp_ready,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]           rsp_state,
   output logic [ID_W-1:0]                                 rsp_id,
   output logic [$clog2(RSP_DEPTH+1)-1:0]                  credits,
   output logic                                            busy,
   output logic                                            err_unexpected
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = $clog2(RSP_DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_DEPTH);

   typedef logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_t;

   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  next_ptr;
   logic [ID_W-1:0]  scan_idx;
   logic [ID_W:0]    scan_sum;
   logic             grant_any;

   logic [ID_W-1:0]  tag_mem [RSP_DEPTH];
   logic [PTR_W-1:0] tag_wr;
   logic [PTR_W-1:0] tag_rd;
   logic [CNT_W-1:0] tag_cnt;
   logic             tag_pop;

   state_t           rsp_state_mem [RSP_DEPTH];
   logic [ID_W-1:0]  rsp_id_mem [RSP_DEPTH];
   logic [PTR_W-1:0] rsp_wr;
   logic [PTR_W-1:0] rsp_rd;
   logic [CNT_W-1:0] rsp_cnt;
   logic             rsp_pop;

   // Handshakes: a requester transfer happens on req_valid[i] & req_ready[i]; a response
   // leaves on rsp_valid & rsp_ready. Valid never depends on ready on either side.
   always_comb begin
      req_ready = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      scan_sum  = '0;
      scan_idx  = '0;
      if (credits != '0) begin
         for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ)) scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            scan_idx = scan_sum[ID_W-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
               grant_any = 1'b1;
               grant_idx = scan_idx;
            end
         end
         if (grant_any) req_ready[grant_idx] = 1'b1;
      end
   end

   assign next_ptr = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);

   // A result with no outstanding tag is dropped rather than buffered.
   assign tag_pop   = hash_out_valid && (tag_cnt != '0);
   assign rsp_valid = (rsp_cnt != '0);
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign rsp_state = rsp_valid ? rsp_state_mem[rsp_rd] : '0;
   assign rsp_id    = rsp_valid ? rsp_id_mem[rsp_rd] : '0;
   assign busy      = (credits != FULL_CNT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr         <= '0;
         hash_in_valid  <= 1'b0;
         hash_state_in  <= '0;
         tag_wr         <= '0;
         tag_rd         <= '0;
         tag_cnt        <= '0;
         rsp_wr         <= '0;
         rsp_rd         <= '0;
         rsp_cnt        <= '0;
         credits        <= FULL_CNT;
         err_unexpected <= 1'b0;
      end else begin
         hash_in_valid <= grant_any;
         if (grant_any) begin
            rr_ptr        <= next_ptr;
            hash_state_in <= req_state[grant_idx];
            tag_wr        <= tag_wr + PTR_W'(1);
         end
         if (tag_pop) begin
            tag_rd <= tag_rd + PTR_W'(1);
            rsp_wr <= rsp_wr + PTR_W'(1);
         end
         if (rsp_pop) rsp_rd <= rsp_rd + PTR_W'(1);
         if (hash_out_valid && (tag_cnt == '0)) err_unexpected <= 1'b1;
         tag_cnt <= tag_cnt + CNT_W'(grant_any) - CNT_W'(tag_pop);
         rsp_cnt <= rsp_cnt + CNT_W'(tag_pop) - CNT_W'(rsp_pop);
         // Credits cover in-flight plus buffered, so the engine can never overrun the FIFO.
         credits <= credits - CNT_W'(grant_any) + CNT_W'(rsp_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (grant_any) tag_mem[tag_wr] <= grant_idx;
      if (tag_pop) begin
         rsp_state_mem[rsp_wr] <= hash_state_out;
         rsp_id_mem[rsp_wr]    <= tag_mem[tag_rd];
      end
   end

endmodule

// File: tb/tb_monolith_hash_arbiter.sv
// Directed bench for monolith_hash_arbiter with a 7-cycle engine model and an
// in-order response scoreboard.
module tb_monolith_hash_arbiter;

   localparam int WW    = 31;
   localparam int SS    = 16;
   localparam int NR    = 4;
   localparam int DEPTH = 8;
   localparam int IDW   = 2;
   localparam int CW    = 4;
   localparam int SW    = WW*SS;
   localparam int RW    = IDW+SW;
   localparam int LAT   = 7;

   typedef logic [SS-1:0][WW-1:0] state_t;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NR-1:0]           req_valid;
   logic [NR-1:0]           req_ready;
   logic [NR-1:0][SS-1:0][WW-1:0] req_state;
   state_t                  hash_state_in;
   logic                    hash_in_valid;
   state_t                  hash_state_out;
   logic                    hash_out_valid;
   logic                    rsp_valid;
   logic                    rsp_ready;
   state_t                  rsp_state;
   logic [IDW-1:0]          rsp_id;
   logic [CW-1:0]           credits;
   logic                    busy;
   logic                    err_unexpected;
   logic                    inject_v;

   monolith_hash_arbiter #(
      .WORD_WIDTH(WW), .STATE_SIZE(SS), .N_REQ(NR), .RSP_DEPTH(DEPTH), .ID_W(IDW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
      .hash_state_in(hash_state_in), .hash_in_valid(hash_in_valid),
      .hash_state_out(hash_state_out), .hash_out_valid(hash_out_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state), .rsp_id(rsp_id),
      .credits(credits), .busy(busy), .err_unexpected(err_unexpected)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- engine model ----------------
   function automatic state_t engine_fn(input state_t s);
      state_t r;
      for (int k = 0; k < SS; k++) r[k] = s[(k+1)%SS] ^ 31'h2A5A5A5A ^ WW'(k);
      return r;
   endfunction

   logic [LAT-1:0] eng_v;
   state_t         eng_s [LAT];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         eng_v <= '0;
      end else begin
         eng_v    <= {eng_v[LAT-2:0], hash_in_valid};
         eng_s[0] <= engine_fn(hash_state_in);
         for (int i = 1; i < LAT; i++) eng_s[i] <= eng_s[i-1];
      end
   end

   assign hash_out_valid = eng_v[LAT-1] | inject_v;
   assign hash_state_out = eng_s[LAT-1];

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] mon_e;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int id, input state_t st);
      exp_q.push_back({IDW'(id), engine_fn(st)});
   endtask

   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_extra: got id %0d, expected no response", rsp_id);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_id", RW'(rsp_id), RW'(mon_e[RW-1 -: IDW]));
            check("rsp_state", RW'(rsp_state), RW'(mon_e[SW-1:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic state_t mk_state(input int tag, input int rq);
      state_t s;
      for (int k = 0; k < SS; k++) s[k] = WW'((tag << 12) | (rq << 8) | k) ^ 31'h0F0F0000;
      return s;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      req_valid = '0;
      rsp_ready = 1'b1;
      while ((credits != CW'(DEPTH) || rsp_valid) && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL drain_timeout: credits %0d required %0d", credits, DEPTH);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          drain;
      logic [NR-1:0] rv;
      logic [NR-1:0] exp_rdy;
      logic [CW-1:0] exp_cr;
   } vec_t;

   localparam int NV = 15;
   vec_t vt [NV];

   // ---------------- main sequence ----------------
   state_t st;
   int     lat;
   int     gidx;
   logic   prev_issue;
   state_t prev_state;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_state = '0;
      rsp_ready = 1'b0;
      inject_v  = 1'b0;

      // Pointer enters the table at 3 (left there by the first sequence).
      vt[0]  = '{1'b1, 4'b0000, 4'b0000, 4'd8};
      vt[1]  = '{1'b0, 4'b0100, 4'b0100, 4'd8};
      vt[2]  = '{1'b0, 4'b1111, 4'b1000, 4'd7};
      vt[3]  = '{1'b0, 4'b1111, 4'b0001, 4'd6};
      vt[4]  = '{1'b0, 4'b1111, 4'b0010, 4'd5};
      vt[5]  = '{1'b0, 4'b1111, 4'b0100, 4'd4};
      vt[6]  = '{1'b0, 4'b1001, 4'b1000, 4'd3};
      vt[7]  = '{1'b0, 4'b1001, 4'b0001, 4'd2};
      vt[8]  = '{1'b1, 4'b0001, 4'b0001, 4'd8};
      vt[9]  = '{1'b0, 4'b0001, 4'b0001, 4'd7};
      vt[10] = '{1'b0, 4'b0110, 4'b0010, 4'd6};
      vt[11] = '{1'b0, 4'b0011, 4'b0001, 4'd5};
      vt[12] = '{1'b0, 4'b1010, 4'b0010, 4'd4};
      vt[13] = '{1'b0, 4'b1010, 4'b1000, 4'd3};
      vt[14] = '{1'b0, 4'b0000, 4'b0000, 4'd2};

      // Reset values
      @(negedge clk);
      check("rst_req_ready", RW'(req_ready), RW'(0));
      check("rst_hash_in_valid", RW'(hash_in_valid), RW'(0));
      check("rst_hash_state_in", RW'(hash_state_in), RW'(0));
      check("rst_rsp_valid", RW'(rsp_valid), RW'(0));
      check("rst_rsp_state", RW'(rsp_state), RW'(0));
      check("rst_rsp_id", RW'(rsp_id), RW'(0));
      check("rst_credits", RW'(credits), RW'(DEPTH));
      check("rst_busy", RW'(busy), RW'(0));
      check("rst_err", RW'(err_unexpected), RW'(0));
      tick();
      reset = 1'b0;

      // Single request from requester 2, word k = k+1
      rsp_ready = 1'b1;
      for (int k = 0; k < SS; k++) st[k] = WW'(k+1);
      req_state[2] = st;
      req_valid    = 4'b0100;
      @(negedge clk);
      check("t1_req_ready", RW'(req_ready), RW'(4'b0100));
      push_exp(2, st);
      tick();
      req_valid = '0;
      @(negedge clk);
      check("t1_issue_valid", RW'(hash_in_valid), RW'(1));
      check("t1_issue_state", RW'(hash_state_in), RW'(st));
      check("t1_busy", RW'(busy), RW'(1));
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      // 7 engine cycles plus the response FIFO register
      check("t1_rsp_latency", RW'(lat), RW'(LAT+1));
      check("t1_rsp_id", RW'(rsp_id), RW'(2));

      // Table-driven round-robin rows
      prev_issue = 1'b0;
      prev_state = '0;
      tick();
      for (int r = 0; r < NV; r++) begin
         if (vt[r].drain) begin
            drain();
            prev_issue = 1'b0;
         end
         for (int i = 0; i < NR; i++) req_state[i] = mk_state(r, i);
         req_valid = vt[r].rv;
         @(negedge clk);
         check($sformatf("tbl%0d_req_ready", r), RW'(req_ready), RW'(vt[r].exp_rdy));
         check($sformatf("tbl%0d_credits", r), RW'(credits), RW'(vt[r].exp_cr));
         check($sformatf("tbl%0d_issue_valid", r), RW'(hash_in_valid), RW'(prev_issue));
         if (prev_issue)
            check($sformatf("tbl%0d_issue_state", r), RW'(hash_state_in), RW'(prev_state));
         prev_issue = (vt[r].exp_rdy != '0);
         if (prev_issue) begin
            gidx = 0;
            for (int i = 0; i < NR; i++) if (vt[r].exp_rdy[i]) gidx = i;
            prev_state = req_state[gidx];
            push_exp(gidx, prev_state);
         end
         tick();
      end
      drain();

      // Credit exhaustion with the consumer stalled
      rsp_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         req_valid    = 4'b0010;
         req_state[1] = mk_state(100 + c, 1);
         @(negedge clk);
         if (c < DEPTH) begin
            check($sformatf("cr%0d_grant", c), RW'(req_ready), RW'(4'b0010));
            push_exp(1, req_state[1]);
         end else begin
            check($sformatf("cr%0d_nogrant", c), RW'(req_ready), RW'(0));
         end
         tick();
      end
      @(negedge clk);
      check("cr_credits_zero", RW'(credits), RW'(0));
      check("cr_busy", RW'(busy), RW'(1));
      repeat (10) tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("cr_pop_cycle_nogrant", RW'(req_ready), RW'(0));
      check("cr_fifo_full_valid", RW'(rsp_valid), RW'(1));
      tick();
      req_state[1] = mk_state(200, 1);
      @(negedge clk);
      check("cr_grant_after_pop", RW'(req_ready), RW'(4'b0010));
      check("cr_credits_one", RW'(credits), RW'(1));
      push_exp(1, req_state[1]);
      tick();
      drain();
      check("cr_queue_empty", RW'(exp_q.size()), RW'(0));

      // Result with nothing in flight
      inject_v = 1'b1;
      tick();
      inject_v = 1'b0;
      @(negedge clk);
      check("err_set", RW'(err_unexpected), RW'(1));
      check("err_rsp_valid", RW'(rsp_valid), RW'(0));
      check("err_credits", RW'(credits), RW'(DEPTH));
      repeat (3) tick();
      @(negedge clk);
      check("err_sticky", RW'(err_unexpected), RW'(1));
      check("err_rsp_valid_later", RW'(rsp_valid), RW'(0));
      tick();

      // Reset with 5 in flight and 2 buffered
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) req_state[i] = mk_state(250, i);
      repeat (7) tick();
      req_valid = '0;
      repeat (3) tick();
      @(negedge clk);
      check("mid_credits", RW'(credits), RW'(1));
      check("mid_rsp_valid", RW'(rsp_valid), RW'(1));
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("mr_hash_in_valid", RW'(hash_in_valid), RW'(0));
      check("mr_hash_state_in", RW'(hash_state_in), RW'(0));
      check("mr_rsp_valid", RW'(rsp_valid), RW'(0));
      check("mr_rsp_state", RW'(rsp_state), RW'(0));
      check("mr_rsp_id", RW'(rsp_id), RW'(0));
      check("mr_credits", RW'(credits), RW'(DEPTH));
      check("mr_busy", RW'(busy), RW'(0));
      check("mr_err", RW'(err_unexpected), RW'(0));
      tick();
      reset     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) req_state[i] = mk_state(300, i);
      @(negedge clk);
      check("post_rst_grant", RW'(req_ready), RW'(4'b0001));
      push_exp(0, req_state[0]);
      tick();
      drain();
      check("post_rst_err", RW'(err_unexpected), RW'(0));
      check("final_queue_empty", RW'(exp_q.size()), RW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
